secure_key_slots: RTL and testbench

SECURE_KEY_SLOTS -- requirements
Module: secure_key_slots

---
 rtl/secure_key_slots.sv | 110 +++++++++++
 tb/tb_secure_key_slots.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/secure_key_slots.sv
// Key slot store with load, XOR-process and multi-pass scrub on clear.
// Key material never leaves the block except as key XOR operand.
module secure_key_slots #(
  parameter int DATA_W       = 32,
  parameter int NUM_SLOTS    = 4,
  parameter int SCRUB_PASSES = 2,
  localparam int SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SLOT_W-1:0]    slot_sel,
  input  logic                 load_valid,
  input  logic [DATA_W-1:0]    load_data,
  input  logic                 clear_req,
  input  logic                 proc_valid,
  input  logic [DATA_W-1:0]    proc_data,
  output logic                 busy,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_err,
  output logic [NUM_SLOTS-1:0] slot_valid
);

  localparam int REM_W = (SCRUB_PASSES > 1) ? $clog2(SCRUB_PASSES) : 1;

  typedef enum logic {IDLE = 1'b0, SCRUB = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [SLOT_W-1:0]     scrub_slot_q, scrub_slot_d;
  logic [DATA_W-1:0]     slot_q [NUM_SLOTS];
  logic [DATA_W-1:0]     slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_err_q, out_err_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      scrub_slot_q <= '0;
      slot_valid_q <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_data_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      scrub_slot_q <= scrub_slot_d;
      slot_valid_q <= slot_valid_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_data_q   <= out_data_d;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clear_req) state_d = SCRUB;
      SCRUB:   if (rem_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCRUB);
  end

  // rem_q counts passes still to go; its parity selects the overwrite pattern,
  // so the last pass (rem_q == 0) always writes zeros.
  always_comb begin
    rem_d        = rem_q;
    scrub_slot_d = scrub_slot_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    out_valid_d  = 1'b0;
    out_err_d    = 1'b0;
    out_data_d   = '0;
    if (state_q == SCRUB) begin
      slot_d[scrub_slot_q] = {DATA_W{rem_q[0]}};
      if (rem_q != '0) rem_d = rem_q - 1'b1;
    end else if (clear_req) begin
      slot_valid_d[slot_sel] = 1'b0;
      scrub_slot_d           = slot_sel;
      rem_d                  = REM_W'(SCRUB_PASSES - 1);
    end else if (load_valid) begin
      if (slot_valid_q[slot_sel]) begin
        out_valid_d = 1'b1;
        out_err_d   = 1'b1;
      end else begin
        slot_d[slot_sel]       = load_data;
        slot_valid_d[slot_sel] = 1'b1;
      end
    end else if (proc_valid) begin
      out_valid_d = 1'b1;
      if (slot_valid_q[slot_sel]) out_data_d = slot_q[slot_sel] ^ proc_data;
      else                        out_err_d  = 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_data   = out_data_q;
  assign slot_valid = slot_valid_q;

endmodule

// File: tb/tb_secure_key_slots.sv
// Directed bench for secure_key_slots: load/process/error paths, scrub timing,
// command priority, busy lockout and reset abort of a scrub.
module tb_secure_key_slots;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  slot_sel;
  logic        load_valid;
  logic [31:0] load_data;
  logic        clear_req;
  logic        proc_valid;
  logic [31:0] proc_data;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
  logic [3:0]  slot_valid;

  int n_checks = 0;
  int n_fail   = 0;

  secure_key_slots #(.DATA_W(32), .NUM_SLOTS(4), .SCRUB_PASSES(2)) dut (
    .clk(clk), .rst_n(rst_n), .slot_sel(slot_sel), .load_valid(load_valid),
    .load_data(load_data), .clear_req(clear_req), .proc_valid(proc_valid),
    .proc_data(proc_data), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_err(out_err), .slot_valid(slot_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; clear_req = 1'b0; proc_valid = 1'b0;
    load_data = '0; proc_data = '0;
  endtask

  task automatic do_load(input logic [1:0] s, input logic [31:0] d);
    slot_sel = s; load_valid = 1'b1; load_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic do_proc(input logic [1:0] s, input logic [31:0] d);
    slot_sel = s; proc_valid = 1'b1; proc_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic do_clear(input logic [1:0] s);
    slot_sel = s; clear_req = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0; slot_sel = '0;
    idle_inputs();
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_slot_valid", slot_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // Load + process on a valid slot
    do_load(2'd1, 32'hDEADBEEF);
    check("load1_slot_valid", slot_valid, 4'b0010);
    check("load1_no_out_valid", out_valid, 0);
    do_proc(2'd1, 32'h0000FFFF);
    check("proc1_valid", out_valid, 1);
    check("proc1_err", out_err, 0);
    check("proc1_data", out_data, 32'hDEAD4110);
    tick();
    check("proc1_data_cleared", out_data, 0);
    check("proc1_valid_cleared", out_valid, 0);

    // Process on an unloaded slot
    do_proc(2'd2, 32'h12345678);
    check("proc_inv_valid", out_valid, 1);
    check("proc_inv_err", out_err, 1);
    check("proc_inv_data", out_data, 0);

    // Overwrite without clear is rejected
    do_load(2'd0, 32'hA5A5A5A5);
    check("load0_no_err", out_err, 0);
    do_load(2'd0, 32'h11111111);
    check("reload_err", out_err, 1);
    check("reload_valid", out_valid, 1);
    check("reload_data", out_data, 0);
    do_proc(2'd0, 32'h0);
    check("reload_keeps_key", out_data, 32'hA5A5A5A5);
    check("reload_proc_err", out_err, 0);
    check("slot_valid_01", slot_valid, 4'b0011);

    // Clear slot0: two scrub passes, commands ignored while busy
    do_clear(2'd0);
    check("scrub_busy_c1", busy, 1);
    check("scrub_sv_cleared", slot_valid, 4'b0010);
    slot_sel = 2'd0; proc_valid = 1'b1; proc_data = 32'h5;
    tick();
    idle_inputs();
    check("scrub_busy_c2", busy, 1);
    check("scrub_pass0_ones", dut.slot_q[0], 32'hFFFFFFFF);
    check("busy_proc_no_valid", out_valid, 0);
    check("busy_proc_no_err", out_err, 0);
    slot_sel = 2'd2; load_valid = 1'b1; load_data = 32'h77;
    tick();
    idle_inputs();
    check("scrub_done_busy", busy, 0);
    check("scrub_pass1_zero", dut.slot_q[0], 0);
    check("busy_load_ignored", slot_valid, 4'b0010);
    check("busy_load_no_err", out_err, 0);
    do_proc(2'd0, 32'h0);
    check("post_scrub_err", out_err, 1);
    check("post_scrub_data", out_data, 0);

    // Same-cycle clear+load+proc: clear wins, others dropped silently
    do_load(2'd3, 32'hCAFEF00D);
    check("load3_sv", slot_valid, 4'b1010);
    slot_sel = 2'd3; clear_req = 1'b1; load_valid = 1'b1; load_data = 32'h1;
    proc_valid = 1'b1; proc_data = 32'h2;
    tick();
    idle_inputs();
    check("prio_busy", busy, 1);
    check("prio_no_valid", out_valid, 0);
    check("prio_no_err", out_err, 0);
    check("prio_sv", slot_valid, 4'b0010);
    tick(); tick();
    check("prio_idle", busy, 0);
    check("prio_slot3_zero", dut.slot_q[3], 0);

    // Reset during the second scrub cycle aborts and zeroes everything
    do_load(2'd2, 32'h22222222);
    check("load2_sv", slot_valid, 4'b0110);
    do_clear(2'd1);
    tick();
    check("abort_mid_ones", dut.slot_q[1], 32'hFFFFFFFF);
    check("abort_mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_sv", slot_valid, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) check($sformatf("abort_slot%0d_zero", i), dut.slot_q[i], 0);
    rst_n = 1'b1;
    do_proc(2'd2, 32'h0);
    check("after_rst_proc_err", out_err, 1);
    check("after_rst_proc_data", out_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
